setting_cmd_decoder: RTL and testbench
======================================

# setting_cmd_decoder

Upstream command stage for the SystemSetting on/off/toggle registers. It takes the byte stream from the host link receiver (one byte per `rxValid` strobe) and parses 3-byte framed commands. Each valid frame becomes a single-cycle `turnOn`/`turnOff`/`toggle` pulse on one lane of a per-setting vector. Each SystemSetting instance connects to one bit of each vector.

## Interface
- `N_SETTINGS`, 8: number of setting lanes, 1..64; an index ≥ `N_SETTINGS` is an error.
- `SYNC_BYTE`, 8'h5A: frame start marker.
- `TIMEOUT_CYCLES`, 1000: maximum clk cycles between bytes inside a frame, ≥ 2.

Ports:
- `clk` in 1: single system clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `rxData` in 8: received byte, valid only when `rxValid` is high.
- `rxValid` in 1: one-cycle strobe per received byte; may occur on consecutive cycles.
- `turnOn` out `N_SETTINGS`: one-hot, one-cycle pulse; sets setting[i].
- `turnOff` out `N_SETTINGS`: one-hot, one-cycle pulse; clears setting[i].
- `toggle` out `N_SETTINGS`: one-hot, one-cycle pulse; inverts setting[i].
- `cmdOk` out 1: one-cycle pulse when a frame is accepted.
- `cmdErr` out 1: one-cycle pulse when a frame is rejected (bad check, bad index, or timeout).
- `errCount` out 8: saturating count of `cmdErr` pulses.

## Operation
- Frame format: `SYNC_BYTE`, then CMD, then CHK.
  - CHK must equal CMD ^ 8'hFF.
  - CMD[7:6] is the action: 00 no-op, 01 on, 10 off, 11 toggle.
  - CMD[5:0] is the setting index.
- FSM states: IDLE, GOT_SYNC, GOT_CMD.
- IDLE:
  - `rxValid` with `rxData==SYNC_BYTE` → GOT_SYNC.
  - Any other byte is dropped silently (no error).
- GOT_SYNC:
  - Any byte, including `SYNC_BYTE`, is latched as CMD → GOT_CMD.
  - There is no resync on a repeated SYNC.
- GOT_CMD: the next byte is CHK; the FSM returns to IDLE unconditionally.
  - Accept when CHK matches and index < `N_SETTINGS`.
    - `cmdOk` pulses.
    - Action 01/10/11 pulses bit[index] of `turnOn`/`turnOff`/`toggle` respectively.
    - Action 00 pulses only `cmdOk`; the index is still range-checked.
  - Reject when CHK mismatches or index ≥ `N_SETTINGS`: `cmdErr` pulses, no lane pulses.
- Timeout:
  - The gap counter clears on every `rxValid` and counts only while the FSM is not in IDLE.
  - When it reaches `TIMEOUT_CYCLES`-1 with no `rxValid` in that cycle: → IDLE and `cmdErr` pulses.
  - If `rxValid` arrives in the same cycle as expiry, the byte wins: it is processed normally and no timeout occurs.
- `errCount`: increments on every `cmdErr` and holds at 255.
- At most one of `turnOn`/`turnOff`/`toggle` is nonzero in any cycle, with exactly one bit set. `cmdOk` and `cmdErr` are never high together.

## Timing
- All outputs are registered.
- Lane pulse and `cmdOk`/`cmdErr` go high in the cycle after the clock edge that samples the CHK byte's `rxValid`. Latency is 1 cycle, pulse width is exactly 1 cycle.
- Back-to-back frames with `rxValid` high every cycle are supported. Throughput is one command per 3 cycles.
- Timeout `cmdErr` goes high the cycle after the expiry edge.
- Reset values (next edge with `rst` high):
  - FSM → IDLE; gap counter and latched CMD cleared.
  - `turnOn`/`turnOff`/`toggle` = 0, `cmdOk`=0, `cmdErr`=0, `errCount`=0.
- Reset mid-frame abandons the partial frame with no `cmdErr`. The first byte after reset is parsed from IDLE.

## Structure
- Shared package `setting_cmd_pkg` holds:
  - action codes: `ACT_NOP`=2'b00, `ACT_ON`=2'b01, `ACT_OFF`=2'b10, `ACT_TOG`=2'b11;
  - FSM state encodings;
  - `SYNC_BYTE` default and the CHK XOR constant 8'hFF.
- One sub-module, `byte_gap_timer`: parameterised counter with `clear`, `enable`, and an `expired` strobe; it implements the timeout.
- Decoder FSM, lane one-hot generation and `errCount` live in the top module.

## Test plan
All scenarios use `N_SETTINGS`=8.
- Send 5A,43,BC on consecutive cycles → `turnOn`=8'h08 for 1 cycle, `cmdOk`=1, `errCount`=0.
- Send 5A,85,7A then immediately 5A,C0,3F → `turnOff`=8'h20, then 3 cycles later `toggle`=8'h01. No gap or stall.
- Send 5A,43,BD (bad check) → `cmdErr`=1, no lane pulse, `errCount`=1. Then send 5A,4A,B5 (index 10) → `cmdErr`, `errCount`=2.
- Send 5A, wait 1000 cycles → `cmdErr` pulse at expiry. Then send 43,BC → no pulses (dropped in IDLE).
- Send 5A,43, assert `rst` for 1 cycle, then send BC → no outputs. Then send 5A,43,BC → `turnOn`=8'h08.
- Send 300 bad frames → `errCount` saturates at 255 and `cmdErr` still pulses each time. Send 5A,00,FF → `cmdOk` only, all lane vectors 0.

Source files
------------

// File: rtl/setting_cmd_decoder_pkg.sv
// Shared types and constants for the setting command decoder.
// Action codes, FSM states and frame constants.
package setting_cmd_pkg;

   typedef enum logic [1:0] {
      ACT_NOP = 2'b00,
      ACT_ON  = 2'b01,
      ACT_OFF = 2'b10,
      ACT_TOG = 2'b11
   } act_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GOT_SYNC = 2'd1,
      GOT_CMD  = 2'd2
   } state_e;

   typedef struct packed {
      act_e       act;
      logic [5:0] idx;
   } cmd_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'h5A;
   localparam logic [7:0] CHK_XOR      = 8'hFF;

endpackage

// File: rtl/setting_cmd_decoder_if.sv
// Byte-in / pulse-out bundle of the setting command decoder.
// master = host link side, slave = decoder.
interface setting_cmd_decoder_if #(
   parameter int N_SETTINGS = 8
);
   logic [7:0]            rxData;
   logic                  rxValid;
   logic [N_SETTINGS-1:0] turnOn;
   logic [N_SETTINGS-1:0] turnOff;
   logic [N_SETTINGS-1:0] toggle;
   logic                  cmdOk;
   logic                  cmdErr;
   logic [7:0]            errCount;

   modport master (
      output rxData, rxValid,
      input  turnOn, turnOff, toggle,
      input  cmdOk, cmdErr, errCount
   );

   modport slave (
      input  rxData, rxValid,
      output turnOn, turnOff, toggle,
      output cmdOk, cmdErr, errCount
   );
endinterface

// File: rtl/setting_cmd_decoder_byte_gap_timer.sv
// Inter-byte gap counter; strobes expired when the gap
// inside a frame reaches CYCLES clocks with no byte.
module byte_gap_timer #(
   parameter int CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(CYCLES);
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt_q;

   // A byte in the expiry cycle clears instead of expiring
   assign expired = enable && !clear && (cnt_q == LAST);

   // Gap count: restarts on each byte, idles outside a frame
   always_ff @(posedge clk) begin
      if (rst || clear || !enable || expired)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/setting_cmd_decoder.sv
// Parses SYNC/CMD/CHK frames into one-hot on/off/toggle
// lane pulses with registered ok/err strobes.
module setting_cmd_decoder
   import setting_cmd_pkg::*;
#(
   parameter int         N_SETTINGS     = 8,
   parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 1000
) (
   input logic                  clk,
   input logic                  rst,
   setting_cmd_decoder_if.slave bus
);
   localparam logic [6:0] NSET = 7'(N_SETTINGS);

   state_e st_q, st_d;
   cmd_t   cmd_q, cmd_d;

   logic [N_SETTINGS-1:0] onehot;
   logic [N_SETTINGS-1:0] on_q, on_d;
   logic [N_SETTINGS-1:0] off_q, off_d;
   logic [N_SETTINGS-1:0] tog_q, tog_d;
   logic                  ok_q, ok_d;
   logic                  err_q, err_d;
   logic [7:0]            errc_q;
   logic                  expired;
   logic                  chk_ok;
   logic                  idx_ok;

   byte_gap_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_gap (
      .clk     (clk),
      .rst     (rst),
      .clear   (bus.rxValid),
      .enable  (st_q != IDLE),
      .expired (expired)
   );

   assign chk_ok = bus.rxData == (8'(cmd_q) ^ CHK_XOR);
   assign idx_ok = {1'b0, cmd_q.idx} < NSET;

   // Lane select for the latched index
   always_comb begin
      onehot = '0;
      for (int i = 0; i < N_SETTINGS; i++)
         onehot[i] = (int'(cmd_q.idx) == i);
   end

   // Frame parser next-state and next-output logic
   always_comb begin
      st_d  = st_q;
      cmd_d = cmd_q;
      on_d  = '0;
      off_d = '0;
      tog_d = '0;
      ok_d  = 1'b0;
      err_d = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (bus.rxValid && bus.rxData == SYNC_BYTE)
               st_d = GOT_SYNC;
         end
         GOT_SYNC: begin
            if (bus.rxValid) begin
               cmd_d = cmd_t'(bus.rxData);
               st_d  = GOT_CMD;
            end else if (expired) begin
               st_d  = IDLE;
               err_d = 1'b1;
            end
         end
         GOT_CMD: begin
            if (bus.rxValid) begin
               st_d = IDLE;
               if (chk_ok && idx_ok) begin
                  ok_d = 1'b1;
                  unique case (cmd_q.act)
                     ACT_ON:  on_d  = onehot;
                     ACT_OFF: off_d = onehot;
                     ACT_TOG: tog_d = onehot;
                     ACT_NOP: ;
                  endcase
               end else begin
                  err_d = 1'b1;
               end
            end else if (expired) begin
               st_d  = IDLE;
               err_d = 1'b1;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   // Parser state and latched command
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= IDLE;
         cmd_q <= '0;
      end else begin
         st_q  <= st_d;
         cmd_q <= cmd_d;
      end
   end

   // Registered pulses and saturating error count
   always_ff @(posedge clk) begin
      if (rst) begin
         on_q   <= '0;
         off_q  <= '0;
         tog_q  <= '0;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
         errc_q <= '0;
      end else begin
         on_q  <= on_d;
         off_q <= off_d;
         tog_q <= tog_d;
         ok_q  <= ok_d;
         err_q <= err_d;
         if (err_d && errc_q != 8'hFF)
            errc_q <= errc_q + 8'd1;
      end
   end

   assign bus.turnOn   = on_q;
   assign bus.turnOff  = off_q;
   assign bus.toggle   = tog_q;
   assign bus.cmdOk    = ok_q;
   assign bus.cmdErr   = err_q;
   assign bus.errCount = errc_q;
endmodule

// File: tb/tb_setting_cmd_decoder.sv
// Bench for setting_cmd_decoder: frame-level model compared
// every cycle, plus literal checks on key scenarios.
module tb_setting_cmd_decoder;
   localparam int TMO = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;

   setting_cmd_decoder_if #(.N_SETTINGS(8)) bus ();

   setting_cmd_decoder #(
      .N_SETTINGS     (8),
      .SYNC_BYTE      (8'h5A),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Frame-level model: collected bytes and idle time
   logic [7:0] q[$];
   int         gap = 0;
   int         m_errc = 0;
   logic [7:0] m_on = '0, m_off = '0, m_tog = '0;
   logic       m_ok = 1'b0, m_err = 1'b0;

   always @(posedge clk) begin
      logic [7:0] c, k;
      m_on = '0; m_off = '0; m_tog = '0;
      m_ok = 1'b0; m_err = 1'b0;
      if (rst) begin
         q.delete();
         gap = 0;
         m_errc = 0;
      end else if (bus.rxValid) begin
         gap = 0;
         if (q.size() > 0 || bus.rxData == 8'h5A)
            q.push_back(bus.rxData);
         if (q.size() == 3) begin
            c = q[1];
            k = q[2];
            if (k == ~c && c[5:0] < 6'd8) begin
               m_ok = 1'b1;
               case (c[7:6])
                  2'd1: m_on  = 8'd1 << c[5:0];
                  2'd2: m_off = 8'd1 << c[5:0];
                  2'd3: m_tog = 8'd1 << c[5:0];
                  default: ;
               endcase
            end else begin
               m_err = 1'b1;
            end
            q.delete();
         end
      end else if (q.size() > 0) begin
         gap++;
         if (gap == TMO) begin
            m_err = 1'b1;
            q.delete();
            gap = 0;
         end
      end
      if (m_err && m_errc < 255)
         m_errc++;
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (bus.turnOn !== m_on || bus.turnOff !== m_off ||
             bus.toggle !== m_tog || bus.cmdOk !== m_ok ||
             bus.cmdErr !== m_err ||
             bus.errCount !== 8'(m_errc)) begin
            fails++;
            $display("FAIL model t=%0t got on=%h off=%h tog=%h ok=%b err=%b ec=%0d want on=%h off=%h tog=%h ok=%b err=%b ec=%0d",
                     $time, bus.turnOn, bus.turnOff, bus.toggle,
                     bus.cmdOk, bus.cmdErr, bus.errCount,
                     m_on, m_off, m_tog, m_ok, m_err, m_errc);
         end
      end
   end

   task automatic lit(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      bus.rxValid = 1'b1;
      bus.rxData  = b;
      @(negedge clk);
      bus.rxValid = 1'b0;
      bus.rxData  = 8'h00;
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
      send(a);
      send(b);
      send(c);
   endtask

   task automatic idle(input int n);
      bus.rxValid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.rxValid = 1'b0;
      bus.rxData  = 8'h00;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      lit("rst_ec", bus.errCount, 8'h00);
      lit("rst_ok", {7'b0, bus.cmdOk}, 8'h00);
      lit("rst_on", bus.turnOn, 8'h00);
      rst = 1'b0;
      idle(2);

      frame(8'h5A, 8'h43, 8'hBC);
      lit("on_idx3", bus.turnOn, 8'h08);
      lit("on_ok", {7'b0, bus.cmdOk}, 8'h01);
      idle(1);
      lit("on_width", bus.turnOn, 8'h00);

      frame(8'h5A, 8'h85, 8'h7A);
      lit("off_idx5", bus.turnOff, 8'h20);
      frame(8'h5A, 8'hC0, 8'h3F);
      lit("tog_idx0", bus.toggle, 8'h01);
      idle(2);

      frame(8'h5A, 8'h43, 8'hBD);
      lit("badchk_err", {7'b0, bus.cmdErr}, 8'h01);
      lit("badchk_ec", bus.errCount, 8'h01);
      frame(8'h5A, 8'h4A, 8'hB5);
      lit("badidx_ec", bus.errCount, 8'h02);
      lit("badidx_on", bus.turnOn, 8'h00);

      frame(8'h5A, 8'h5A, 8'hA5);
      lit("sync_as_cmd", bus.turnOn, 8'h00);
      lit("sync_as_cmd_ec", bus.errCount, 8'h03);
      idle(3);

      send(8'h5A);
      idle(TMO - 1);
      lit("tmo_early", {7'b0, bus.cmdErr}, 8'h00);
      idle(1);
      lit("tmo_err", {7'b0, bus.cmdErr}, 8'h01);
      lit("tmo_ec", bus.errCount, 8'h04);
      send(8'h43);
      send(8'hBC);
      lit("tmo_drop", bus.turnOn, 8'h00);
      idle(2);

      send(8'h5A);
      idle(TMO - 1);
      send(8'h43);
      idle(TMO - 1);
      send(8'hBC);
      lit("tmo_edge_on", bus.turnOn, 8'h08);
      lit("tmo_edge_ec", bus.errCount, 8'h04);
      idle(2);

      send(8'h5A);
      send(8'h43);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(8'hBC);
      lit("rst_abandon", {7'b0, bus.cmdErr}, 8'h00);
      lit("rst_ec0", bus.errCount, 8'h00);
      frame(8'h5A, 8'h43, 8'hBC);
      lit("rst_after_on", bus.turnOn, 8'h08);
      idle(2);

      for (int i = 0; i < 300; i++)
         frame(8'h5A, 8'h43, 8'hBD);
      lit("sat_ec", bus.errCount, 8'hFF);
      lit("sat_err", {7'b0, bus.cmdErr}, 8'h01);
      frame(8'h5A, 8'h00, 8'hFF);
      lit("nop_ok", {7'b0, bus.cmdOk}, 8'h01);
      lit("nop_lanes", bus.turnOn | bus.turnOff | bus.toggle, 8'h00);
      lit("nop_ec", bus.errCount, 8'hFF);
      idle(3);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
